// File: rtl/multdiv_seq.sv
// ============================================================================
// Module   : multdiv_seq
// Brief    : Iterative signed multiply / divide sequencer for the execute
//            stage. Booth shift-add loop for MULT, non-restoring
//            shift-subtract loop on magnitudes for DIV.
// Options  : define MULTDIV_RADIX4_EN to run MULT as radix-4 Booth
//            (16 iterations, 34-bit accumulator) instead of radix-2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

`ifdef MULTDIV_RADIX4_EN
    // Two guard bits so that +/-2M never overflows the running partial product.
    localparam int c_acc_w    = WIDTH + 2;
    localparam int c_mul_iter = WIDTH / 2;
`else
    // One guard bit absorbs the -M step when M is the most negative value.
    localparam int c_acc_w    = WIDTH + 1;
    localparam int c_mul_iter = WIDTH;
`endif
    localparam int c_div_iter = WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [c_acc_w-1:0] r_acc;     // Booth high half, or DIV partial remainder
    logic [WIDTH-1:0]   r_q;       // Booth multiplier/low half, or DIV quotient
    logic               r_qm1;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_result;
    logic               r_exc;
    logic               r_rdy;
    logic               r_busy;

    logic               w_start;
    logic [WIDTH-1:0]   w_abs_a;
    logic [c_acc_w-1:0] w_mext;
    logic [c_acc_w-1:0] w_booth_sum;
    logic [c_acc_w-1:0] w_mul_acc_nxt;
    logic [WIDTH-1:0]   w_mul_q_nxt;
    logic               w_mul_qm1_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_mul_ovf;
    logic [WIDTH-1:0]   w_dvsr;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_div_nxt;
    logic [WIDTH-1:0]   w_div_q_nxt;
    logic [WIDTH-1:0]   w_quo;
    logic               w_div_ovf;
    logic               w_div_zero;

    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_abs_a = data_operandA[WIDTH-1] ? (-data_operandA) : data_operandA;
    assign w_mext  = {{(c_acc_w-WIDTH){r_b[WIDTH-1]}}, r_b};

`ifdef MULTDIV_RADIX4_EN
    logic [c_acc_w-1:0] w_m2ext;
    assign w_m2ext = {w_mext[c_acc_w-2:0], 1'b0};

    // Radix-4 Booth recode of {q[1:0], q_-1} into 0 / +-M / +-2M
    always_comb begin
        w_booth_sum = r_acc;
        case ({r_q[1:0], r_qm1})
            3'b001, 3'b010: w_booth_sum = r_acc + w_mext;
            3'b011:         w_booth_sum = r_acc + w_m2ext;
            3'b100:         w_booth_sum = r_acc - w_m2ext;
            3'b101, 3'b110: w_booth_sum = r_acc - w_mext;
            default:        w_booth_sum = r_acc;
        endcase
    end

    assign w_mul_acc_nxt = {{2{w_booth_sum[c_acc_w-1]}}, w_booth_sum[c_acc_w-1:2]};
    assign w_mul_q_nxt   = {w_booth_sum[1:0], r_q[WIDTH-1:2]};
    assign w_mul_qm1_nxt = r_q[1];
`else
    // Radix-2 Booth step selected by {q[0], q_-1}
    always_comb begin
        w_booth_sum = r_acc;
        case ({r_q[0], r_qm1})
            2'b01:   w_booth_sum = r_acc + w_mext;
            2'b10:   w_booth_sum = r_acc - w_mext;
            default: w_booth_sum = r_acc;
        endcase
    end

    assign w_mul_acc_nxt = {w_booth_sum[c_acc_w-1], w_booth_sum[c_acc_w-1:1]};
    assign w_mul_q_nxt   = {w_booth_sum[0], r_q[WIDTH-1:1]};
    assign w_mul_qm1_nxt = r_q[0];
`endif

    // After the last shift the low 64 bits of {acc, q} hold the full product.
    assign w_prod    = {r_acc[WIDTH-1:0], r_q};
    assign w_mul_ovf = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});

    // Non-restoring step: the remainder stays within [-|B|, |B|), so bit WIDTH
    // is its sign and the shifted value still fits in WIDTH+1 bits.
    assign w_dvsr      = r_b[WIDTH-1] ? (-r_b) : r_b;
    assign w_rem_sh    = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_div_nxt   = r_acc[WIDTH] ? (w_rem_sh + {1'b0, w_dvsr})
                                      : (w_rem_sh - {1'b0, w_dvsr});
    assign w_div_q_nxt = {r_q[WIDTH-2:0], ~w_div_nxt[WIDTH]};

    assign w_quo      = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? (-r_q) : r_q;
    assign w_div_zero = (r_b == '0);
    assign w_div_ovf  = (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (r_b == '1);

    // Sequencer: start/restart, iteration, result capture on entry to DONE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_qm1    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
        end else if (w_start) begin
            // MULT wins when both start pulses arrive together.
            r_state <= ctrl_MULT ? S_MUL : S_DIV;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_q     <= ctrl_MULT ? data_operandA : w_abs_a;
            r_qm1   <= 1'b0;
            r_a     <= data_operandA;
            r_b     <= data_operandB;
            r_rdy   <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                S_MUL: begin
                    if (r_cnt == CNT_W'(c_mul_iter)) begin
                        r_result <= w_prod[WIDTH-1:0];
                        r_exc    <= w_mul_ovf;
                        r_rdy    <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_acc <= w_mul_acc_nxt;
                        r_q   <= w_mul_q_nxt;
                        r_qm1 <= w_mul_qm1_nxt;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    if (r_cnt == CNT_W'(c_div_iter)) begin
                        r_result <= w_div_zero ? '0 : w_quo;
                        r_exc    <= w_div_zero | w_div_ovf;
                        r_rdy    <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_acc <= c_acc_w'($signed(w_div_nxt));
                        r_q   <= w_div_q_nxt;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_rdy   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_rdy   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign busy           = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_multdiv_seq.sv
// ============================================================================
// Module   : tb_multdiv_seq
// Brief    : Self-checking bench for multdiv_seq. Expected results go into a
//            scoreboard queue at each start and are popped at data_resultRDY.
//            Honours MULTDIV_RADIX4_EN for the MUL latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multdiv_seq;

`ifdef MULTDIV_RADIX4_EN
    localparam int c_mul_lat = 17;
`else
    localparam int c_mul_lat = 33;
`endif
    localparam int c_div_lat = 33;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    multdiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference models built on the simulator's own signed arithmetic
    function automatic exp_t ref_mul(input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint p;
        p     = longint'($signed(a)) * longint'($signed(b));
        e.res = p[31:0];
        e.exc = (p[63:32] != {32{p[31]}});
        return e;
    endfunction

    function automatic exp_t ref_div(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (b == 32'h0) begin
            e.res = 32'h0;
            e.exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000;
            e.exc = 1'b1;
        end else begin
            e.res = $signed(a) / $signed(b);
            e.exc = 1'b0;
        end
        return e;
    endfunction

    // One-cycle start pulse; returns at the falling edge after the start edge.
    task automatic start_op(input bit m, input bit d, input logic [31:0] a,
                            input logic [31:0] b, input bit push,
                            input logic [31:0] er, input logic ee);
        exp_t e;
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        if (push) begin
            e.res = er;
            e.exc = ee;
            sb.push_back(e);
        end
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    // Waits for RDY, checking latency, busy window, scoreboard and pulse width.
    task automatic wait_result(input string tag, input int exp_lat);
        int   n;
        bit   busy_ok;
        exp_t e;
        n       = 0;
        busy_ok = 1'b1;
        while (data_resultRDY !== 1'b1 && n < 200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clock);
            n++;
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
        check({tag, " latency"}, n, exp_lat);
        check({tag, " busy window"}, {31'b0, busy_ok}, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " result"}, data_result, e.res);
            check({tag, " exception"}, {31'b0, data_exception}, {31'b0, e.exc});
        end else begin
            check({tag, " scoreboard empty"}, 32'd0, 32'd1);
        end
        @(negedge clock);
        check({tag, " rdy one cycle"}, {31'b0, data_resultRDY}, 32'd0);
        check({tag, " busy drops"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = ref_mul(a, b);
        start_op(1'b1, 1'b0, a, b, 1'b1, e.res, e.exc);
        wait_result(tag, c_mul_lat);
    endtask

    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = ref_div(a, b);
        start_op(1'b0, 1'b1, a, b, 1'b1, e.res, e.exc);
        wait_result(tag, c_div_lat);
    endtask

    initial begin
        bit          rdy_seen;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset state
        repeat (2) @(negedge clock);
        check("reset result", data_result, 32'h0);
        check("reset exc", {31'b0, data_exception}, 32'h0);
        check("reset rdy", {31'b0, data_resultRDY}, 32'h0);
        check("reset busy", {31'b0, busy}, 32'h0);
        reset = 1'b0;

        // MUL directed cases with hand-computed expectations
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 1'b0);
        wait_result("mul 7*-3", c_mul_lat);
        start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0, 1'b1);
        check("hold after start", data_result, 32'hFFFF_FFEB);
        wait_result("mul 2^16*2^16", c_mul_lat);
        start_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h1, 1'b0);
        wait_result("mul -1*-1", c_mul_lat);
        start_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1);
        wait_result("mul min*-1", c_mul_lat);
        start_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0, 1'b1);
        wait_result("mul min*min", c_mul_lat);
        start_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2, 1'b1, 32'hFFFF_FFFE, 1'b1);
        wait_result("mul max*2", c_mul_lat);

        // DIV directed cases
        start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 1'b0);
        wait_result("div -7/2", c_div_lat);
        start_op(1'b0, 1'b1, 32'd100, 32'd0, 1'b1, 32'h0, 1'b1);
        wait_result("div 100/0", c_div_lat);
        start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1);
        wait_result("div min/-1", c_div_lat);
        start_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 1'b0);
        wait_result("div 7/-2", c_div_lat);
        start_op(1'b0, 1'b1, 32'd1000, 32'd7, 1'b1, 32'd142, 1'b0);
        wait_result("div 1000/7", c_div_lat);
        start_op(1'b0, 1'b1, 32'h8000_0000, 32'd2, 1'b1, 32'hC000_0000, 1'b0);
        wait_result("div min/2", c_div_lat);
        start_op(1'b0, 1'b1, 32'd5, 32'd7, 1'b1, 32'd0, 1'b0);
        wait_result("div 5/7", c_div_lat);

        // Random operands against the reference models
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i[0]) rb = rb >> ($urandom_range(31, 0));
            do_mul("mul rnd", ra, rb);
            do_div("div rnd", ra, rb);
        end

        // Restart: MUL aborted by a DIV ten cycles later, no RDY for the MUL
        start_op(1'b1, 1'b0, 32'd3, 32'd4, 1'b0, 32'h0, 1'b0);
        rdy_seen = 1'b0;
        repeat (8) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0) rdy_seen = 1'b1;
        end
        start_op(1'b0, 1'b1, 32'd20, 32'd5, 1'b1, 32'd4, 1'b0);
        check("restart no early rdy", {31'b0, rdy_seen}, 32'd0);
        wait_result("restart div 20/5", c_div_lat);

        // Simultaneous starts: MULT wins
        start_op(1'b1, 1'b1, 32'd6, 32'd2, 1'b1, 32'd12, 1'b0);
        wait_result("mult+div together", c_mul_lat);

        // Async reset mid-MUL
        start_op(1'b1, 1'b0, 32'd5, 32'd5, 1'b0, 32'h0, 1'b0);
        repeat (14) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("async reset result", data_result, 32'h0);
        check("async reset busy", {31'b0, busy}, 32'h0);
        check("async reset exc", {31'b0, data_exception}, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        rdy_seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0) rdy_seen = 1'b1;
        end
        check("no rdy after reset", {31'b0, rdy_seen}, 32'd0);
        start_op(1'b1, 1'b0, 32'd5, 32'd5, 1'b1, 32'd25, 1'b0);
        wait_result("mul 5*5 after reset", c_mul_lat);

        check("scoreboard drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
